mux_gate_unit: RTL and testbench

- Registered 2-input logic unit producing bitwise AND, NAND and NOR of operands a and b.
- Every gate function is built only from 2:1 multiplexers, with a as select and b/constant as data. No direct &, |, ~& or ~| operators on the data path.
- Sits as a leaf datapath block. Results are captured on the rising edge of clk with an accompanying valid flag.

---
 rtl/mux_gate_unit_if.sv | 30 +++
 rtl/mux_gate_unit.sv | 73 +++++++
 tb/tb_mux_gate_unit.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mux_gate_unit_if.sv
// mux_gate_unit_if: operand/result bundle for mux_gate_unit.
//   in_valid  operands a/b are valid this cycle
//   a         operand A (per-bit mux select)
//   b         operand B (per-bit mux data)
//   and_      registered a AND b
//   nand_     registered NOT(a AND b)
//   nor_      registered NOT(a OR b)
//   out_valid registered copy of in_valid
// master: operand source / result sink. slave: the gate unit.
interface mux_gate_unit_if #(
    parameter int unsigned WIDTH = 1
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] and_;
    logic [WIDTH-1:0] nand_;
    logic [WIDTH-1:0] nor_;
    logic             out_valid;

    modport master (
        output in_valid, a, b,
        input  and_, nand_, nor_, out_valid
    );

    modport slave (
        input  in_valid, a, b,
        output and_, nand_, nor_, out_valid
    );
endinterface

// File: rtl/mux_gate_unit.sv
// mux_gate_unit: registered AND / NAND / NOR built purely from 2:1 muxes.
// Each bit is an independent slice; a[i] is the mux select, b[i] or a
// constant is the data. Results appear one clk after the operands.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset; clears all outputs to 0
//   bus  mux_gate_unit_if.slave (in_valid, a, b -> and_, nand_, nor_, out_valid)
// Optional feature macro MUX_GATE_HOLD_EN: when defined, results load only on
// edges with in_valid=1 and hold otherwise; out_valid always tracks in_valid.
module mux_gate_unit #(
    parameter int unsigned WIDTH = 1
) (
    input  logic           clk,
    input  logic           rst,
    mux_gate_unit_if.slave bus
);

    function automatic logic mux2(input logic sel, input logic d1, input logic d0);
        return sel ? d1 : d0;
    endfunction

    logic [WIDTH-1:0] b_n;
    logic [WIDTH-1:0] and_d;
    logic [WIDTH-1:0] nand_d;
    logic [WIDTH-1:0] nor_d;

    logic [WIDTH-1:0] and_q;
    logic [WIDTH-1:0] nand_q;
    logic [WIDTH-1:0] nor_q;
    logic             valid_q;

    always_comb begin
        b_n    = '0;
        and_d  = '0;
        nand_d = '0;
        nor_d  = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            // Inverter as a mux: b selects between constants.
            b_n[i]    = mux2(bus.b[i], 1'b0, 1'b1);
            and_d[i]  = mux2(bus.a[i], bus.b[i], 1'b0);
            nand_d[i] = mux2(bus.a[i], b_n[i], 1'b1);
            nor_d[i]  = mux2(bus.a[i], 1'b0, b_n[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            and_q   <= '0;
            nand_q  <= '0;   // deliberately 0, not nand(0,0)
            nor_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= bus.in_valid;
`ifdef MUX_GATE_HOLD_EN
            if (bus.in_valid) begin
                and_q  <= and_d;
                nand_q <= nand_d;
                nor_q  <= nor_d;
            end
`else
            and_q  <= and_d;
            nand_q <= nand_d;
            nor_q  <= nor_d;
`endif
        end
    end

    assign bus.and_      = and_q;
    assign bus.nand_     = nand_q;
    assign bus.nor_      = nor_q;
    assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_mux_gate_unit.sv
// Testbench for mux_gate_unit: a WIDTH=1 and a WIDTH=8 instance share clk/rst
// and are driven from one table of directed vectors, plus hand-written
// sequences for reset, valid latency and mid-operation reset.
module tb_mux_gate_unit;

    logic clk;
    logic rst;

    int n_tests;
    int n_fail;

    mux_gate_unit_if #(.WIDTH(1)) if1 ();
    mux_gate_unit_if #(.WIDTH(8)) if8 ();

    mux_gate_unit #(.WIDTH(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    mux_gate_unit #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (if8.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a8;
        logic [7:0] b8;
        logic [7:0] and8;
        logic [7:0] nand8;
        logic [7:0] nor8;
        logic       a1;
        logic       b1;
        logic       and1;
        logic       nand1;
        logic       nor1;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] e_and8, input logic [7:0] e_nand8,
                           input logic [7:0] e_nor8, input logic e_and1, input logic e_nand1,
                           input logic e_nor1, input logic e_valid);
        chk({tag, " and8"},   if8.and_,  e_and8);
        chk({tag, " nand8"},  if8.nand_, e_nand8);
        chk({tag, " nor8"},   if8.nor_,  e_nor8);
        chk({tag, " ov8"},    {7'd0, if8.out_valid}, {7'd0, e_valid});
        chk({tag, " and1"},   {7'd0, if1.and_},  {7'd0, e_and1});
        chk({tag, " nand1"},  {7'd0, if1.nand_}, {7'd0, e_nand1});
        chk({tag, " nor1"},   {7'd0, if1.nor_},  {7'd0, e_nor1});
        chk({tag, " ov1"},    {7'd0, if1.out_valid}, {7'd0, e_valid});
    endtask

    task automatic drive(input logic v, input logic [7:0] a8, input logic [7:0] b8,
                         input logic a1, input logic b1);
        if8.in_valid = v;
        if8.a        = a8;
        if8.b        = b8;
        if1.in_valid = v;
        if1.a        = a1;
        if1.b        = b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] ra;
    logic [7:0] rb;

    initial begin
        n_tests = 0;
        n_fail  = 0;

        vecs[0] = '{8'hF0, 8'hCC, 8'hC0, 8'h3F, 8'h03, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[1] = '{8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'hAA, 8'h55, 8'h00, 8'hFF, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'h0F, 8'h3C, 8'h0C, 8'hF3, 8'hC0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[5] = '{8'h81, 8'h01, 8'h01, 8'hFE, 8'h7E, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        // Reset asserted away from any edge with a=1,b=1: outputs clear at once.
        drive(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1);
        rst = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_all("reset", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        chk_all("reset_hold", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        #3;
        rst = 1'b0;

        // Table: operands driven between edges, checked just after the edge.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, vecs[i].a8, vecs[i].b8, vecs[i].a1, vecs[i].b1);
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].and8, vecs[i].nand8, vecs[i].nor8,
                    vecs[i].and1, vecs[i].nand1, vecs[i].nor1, 1'b1);
            chk($sformatf("vec%0d nand_is_not_and", i), if8.nand_, ~if8.and_);
        end

        // One-cycle valid pulse, then idle zeros.
        drive(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1);
        tick();
        chk_all("pulse", 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        tick();
`ifdef MUX_GATE_HOLD_EN
        chk_all("idle_hold", 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
`else
        chk_all("idle", 8'h00, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0);
`endif
        tick();
        chk("idle2 ov8", {7'd0, if8.out_valid}, 8'h00);

        // Random stream, checked against a behavioural model.
        for (int i = 0; i < 8; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            drive(1'b1, ra, rb, ra[0], rb[0]);
            tick();
            chk($sformatf("rnd%0d and8", i),  if8.and_,  ra & rb);
            chk($sformatf("rnd%0d nand8", i), if8.nand_, ~(ra & rb));
            chk($sformatf("rnd%0d nor8", i),  if8.nor_,  ~(ra | rb));
        end

        // Mid-operation reset between edges, then release with new operands.
        drive(1'b1, 8'hFF, 8'h0F, 1'b1, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        chk_all("midrst", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all("midrst_hold", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'h5A, 8'hC3, 1'b1, 1'b0);
        #2;
        rst = 1'b0;
        tick();
        chk_all("post_rst", 8'h42, 8'hBD, 8'h24, 1'b0, 1'b1, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
